// File: rtl/vend_if.sv
// Signal bundle between the vending-dispenser core and its surroundings:
// the upstream sell request, the mechanical sensors, and the actuator/status outputs.
interface vend_if #(
  parameter int CNT_W = 16
);
  logic             sell;
  logic [1:0]       change;
  logic             drop_sense;
  logic             coin_sense;
  logic             clr_fault;
  logic             motor_on;
  logic             hopper_on;
  logic             busy;
  logic             done;
  logic             fault;
  logic             ovf;
  logic [CNT_W-1:0] vend_cnt;

  modport slave (
    input  sell, change, drop_sense, coin_sense, clr_fault,
    output motor_on, hopper_on, busy, done, fault, ovf, vend_cnt
  );

  modport master (
    output sell, change, drop_sense, coin_sense, clr_fault,
    input  motor_on, hopper_on, busy, done, fault, ovf, vend_cnt
  );
endinterface

// File: rtl/vend_dispenser.sv
// Product/change delivery sequencer: queues sell requests, runs motor then hopper per coin,
// waits on sensors with a timeout, and parks in a sticky fault until cleared.
module vend_dispenser #(
  parameter int MOTOR_CYC = 8,
  parameter int TIMEOUT   = 64,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 16
) (
  input logic  clk,
  input logic  rstn,
  vend_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int TMAX = (TIMEOUT > MOTOR_CYC) ? TIMEOUT : MOTOR_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_MOTOR, S_WAIT_DROP, S_HOPPER, S_WAIT_COIN, S_DONE, S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       coins_q, coins_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [1:0]       fifo_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             motor_on_q, hopper_on_q, done_q, fault_q, ovf_q;
  logic [CNT_W-1:0] vend_cnt_q;

  logic             empty, full, pop, push, sell_drop;
  logic [1:0]       sell_coins;

  assign empty      = (count_q == '0);
  assign full       = (count_q == (AW+1)'(DEPTH));
  assign pop        = (state_q == S_IDLE) && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push       = bus.sell && (!full || pop);
  assign sell_drop  = bus.sell && full && !pop;
  assign sell_coins = (bus.change == 2'd3) ? 2'd2 : bus.change;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= sell_coins;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    coins_d = coins_q;
    tmr_d   = tmr_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          coins_d = fifo_q[rd_ptr_q];
          tmr_d   = TW'(MOTOR_CYC - 1);
          state_d = S_MOTOR;
        end
      end
      S_MOTOR: begin
        if (tmr_q == '0) begin
          tmr_d   = TW'(TIMEOUT - 1);
          state_d = S_WAIT_DROP;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_WAIT_DROP: begin
        // Sensor is checked before the terminal count so a last-cycle confirmation wins.
        if (bus.drop_sense) begin
          state_d = (coins_q != '0) ? S_HOPPER : S_DONE;
        end else if (tmr_q == '0) begin
          state_d = S_FAULT;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_HOPPER: begin
        tmr_d   = TW'(TIMEOUT - 1);
        state_d = S_WAIT_COIN;
      end
      S_WAIT_COIN: begin
        if (bus.coin_sense) begin
          coins_d = coins_q - 1'b1;
          state_d = (coins_q == 2'd1) ? S_DONE : S_HOPPER;
        end else if (tmr_q == '0) begin
          state_d = S_FAULT;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: if (bus.clr_fault) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      coins_q     <= '0;
      tmr_q       <= '0;
      motor_on_q  <= 1'b0;
      hopper_on_q <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      ovf_q       <= 1'b0;
      vend_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      coins_q     <= coins_d;
      tmr_q       <= tmr_d;
      motor_on_q  <= (state_d == S_MOTOR);
      hopper_on_q <= (state_d == S_HOPPER);
      done_q      <= (state_d == S_DONE);
      fault_q     <= (state_d == S_FAULT);
      if (state_d == S_DONE && vend_cnt_q != '1) vend_cnt_q <= vend_cnt_q + 1'b1;
      if (sell_drop)          ovf_q <= 1'b1;
      else if (bus.clr_fault) ovf_q <= 1'b0;
    end
  end

  assign bus.motor_on  = motor_on_q;
  assign bus.hopper_on = hopper_on_q;
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;
  assign bus.ovf       = ovf_q;
  assign bus.vend_cnt  = vend_cnt_q;
  assign bus.busy      = (state_q != S_IDLE) || !empty;
endmodule
